// File: rtl/fsm_ctrl_pkg.sv
// Shared definitions for the multi-channel start/done/fault sequencer.
// State codes are fixed for compatibility with existing status decoders.
package fsm_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_RUN   = 3'd1;
    localparam state_t S_DONE  = 3'd2;
    localparam state_t S_FAULT = 3'd3;

endpackage

// File: rtl/fsm_ctrl_nch_if.sv
// Request/status bundle between per-channel request logic and the sequencer.
// master drives requests and config, slave (the sequencer) drives status.
interface fsm_ctrl_nch_if
    import fsm_ctrl_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int TMO_W = 16
);

    logic [NCH-1:0]         in_start;
    logic [NCH-1:0]         in_done;
    logic [NCH-1:0]         in_fault;
    logic [NCH-1:0]         in_clr;
    logic [TMO_W-1:0]       cfg_timeout;

    logic [NCH-1:0]         out_busy;
    logic [NCH-1:0]         out_error;
    logic [NCH-1:0]         out_tmo;
    logic [NCH*STATE_W-1:0] state_q;
    logic                   any_busy;
    logic                   any_error;

    modport master (
        output in_start, in_done, in_fault, in_clr, cfg_timeout,
        input  out_busy, out_error, out_tmo, state_q, any_busy, any_error
    );

    modport slave (
        input  in_start, in_done, in_fault, in_clr, cfg_timeout,
        output out_busy, out_error, out_tmo, state_q, any_busy, any_error
    );

endinterface

// File: rtl/fsm_ch_core.sv
// One IDLE/RUN/DONE/FAULT channel with RUN watchdog and optional sticky fault.
// All outputs are decoded from registered state only.
module fsm_ch_core
    import fsm_ctrl_pkg::*;
#(
    parameter int TMO_W       = 16,
    parameter bit FAULT_LATCH = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             done,
    input  logic             fault,
    input  logic             clr,
    input  logic [TMO_W-1:0] cfg_timeout,
    output logic             busy,
    output logic             error,
    output logic             tmo_flag,
    output state_t           state_q
);

    state_t           state;
    logic [TMO_W-1:0] cnt;
    logic             tmo;
    logic             tmo_hit;
    logic             fault_exit;

    // Live compare: lowering cfg_timeout below cnt faults on the next edge.
    assign tmo_hit    = (cfg_timeout != '0) && (cnt >= cfg_timeout - TMO_W'(1));
    assign fault_exit = FAULT_LATCH ? (clr && !start) : !start;

    // NOTE: sequential state uses non-blocking assignments so every channel
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            tmo   <= 1'b0;
        end else if (fault) begin
            if (state != S_FAULT) tmo <= 1'b0;
            state <= S_FAULT;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
                S_RUN: begin
                    if (done) begin
                        state <= S_DONE;
                    end else if (tmo_hit) begin
                        state <= S_FAULT;
                        tmo   <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + TMO_W'(1);
                    end
                end
                S_DONE: if (!start) state <= S_IDLE;
                S_FAULT: if (fault_exit) begin
                    state <= S_IDLE;
                    tmo   <= 1'b0;
                end
                default: begin
                    state <= S_FAULT;
                    tmo   <= 1'b0;
                end
            endcase
        end
    end

    assign state_q  = state;
    assign busy     = (state == S_RUN);
    assign error    = (state == S_FAULT);
    assign tmo_flag = tmo && (state == S_FAULT);

endmodule

// File: rtl/fsm_ctrl_nch.sv
// NCH independent channel sequencers sharing clock, reset and watchdog limit,
// with packed state export and any-busy/any-error aggregation.
module fsm_ctrl_nch
    import fsm_ctrl_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int TMO_W       = 16,
    parameter bit FAULT_LATCH = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    fsm_ctrl_nch_if.slave bus
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        fsm_ch_core #(
            .TMO_W      (TMO_W),
            .FAULT_LATCH(FAULT_LATCH)
        ) u_core (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (bus.in_start[i]),
            .done       (bus.in_done[i]),
            .fault      (bus.in_fault[i]),
            .clr        (bus.in_clr[i]),
            .cfg_timeout(bus.cfg_timeout),
            .busy       (bus.out_busy[i]),
            .error      (bus.out_error[i]),
            .tmo_flag   (bus.out_tmo[i]),
            .state_q    (bus.state_q[i*STATE_W +: STATE_W])
        );
    end

    assign bus.any_busy  = |bus.out_busy;
    assign bus.any_error = |bus.out_error;

endmodule

// File: tb/tb_fsm_ctrl_nch.sv
// Bench for fsm_ctrl_nch: latched and auto-exit builds driven in parallel,
// compared every cycle against a phase/age channel model.
module tb_fsm_ctrl_nch;
    import fsm_ctrl_pkg::*;

    localparam int NCH   = 4;
    localparam int TMO_W = 16;
    localparam int SW    = STATE_W;
    localparam int AGE_MAX = (1 << TMO_W) - 1;
    localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2, P_FAULT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]   s_start = '0, s_done = '0, s_fault = '0, s_clr = '0;
    logic [TMO_W-1:0] s_tmo   = '0;

    fsm_ctrl_nch_if #(.NCH(NCH), .TMO_W(TMO_W)) bus_l ();
    fsm_ctrl_nch_if #(.NCH(NCH), .TMO_W(TMO_W)) bus_a ();

    assign bus_l.in_start = s_start;  assign bus_a.in_start = s_start;
    assign bus_l.in_done  = s_done;   assign bus_a.in_done  = s_done;
    assign bus_l.in_fault = s_fault;  assign bus_a.in_fault = s_fault;
    assign bus_l.in_clr   = s_clr;    assign bus_a.in_clr   = s_clr;
    assign bus_l.cfg_timeout = s_tmo; assign bus_a.cfg_timeout = s_tmo;

    fsm_ctrl_nch #(.NCH(NCH), .TMO_W(TMO_W), .FAULT_LATCH(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(bus_l.slave));
    fsm_ctrl_nch #(.NCH(NCH), .TMO_W(TMO_W), .FAULT_LATCH(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Model: v=0 latched build, v=1 auto-exit build. age = RUN edges seen so far.
    int m_ph  [2][NCH];
    int m_age [2][NCH];
    bit m_tmo [2][NCH];

    task automatic model_reset();
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < NCH; i++) begin
                m_ph[v][i] = P_IDLE; m_age[v][i] = 0; m_tmo[v][i] = 1'b0;
            end
    endtask

    task automatic model_step();
        int lim;
        lim = int'(s_tmo);
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < NCH; i++) begin
                if (s_fault[i]) begin
                    if (m_ph[v][i] != P_FAULT) m_tmo[v][i] = 1'b0;
                    m_ph[v][i] = P_FAULT;
                end else if (m_ph[v][i] == P_IDLE) begin
                    if (s_start[i]) begin m_ph[v][i] = P_RUN; m_age[v][i] = 0; end
                end else if (m_ph[v][i] == P_RUN) begin
                    if (s_done[i]) m_ph[v][i] = P_DONE;
                    else if (lim != 0 && m_age[v][i] + 1 >= lim) begin
                        m_ph[v][i] = P_FAULT; m_tmo[v][i] = 1'b1;
                    end else if (m_age[v][i] < AGE_MAX) m_age[v][i]++;
                end else if (m_ph[v][i] == P_DONE) begin
                    if (!s_start[i]) m_ph[v][i] = P_IDLE;
                end else begin
                    if (v == 0 ? (s_clr[i] && !s_start[i]) : !s_start[i]) begin
                        m_ph[v][i] = P_IDLE; m_tmo[v][i] = 1'b0;
                    end
                end
            end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    function automatic logic [NCH*SW-1:0] exp_state(input int v);
        logic [NCH*SW-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) r[i*SW +: SW] = SW'(m_ph[v][i]);
        return r;
    endfunction

    // {busy, error, tmo, any_busy, any_error}
    function automatic logic [3*NCH+1:0] exp_flags(input int v);
        logic [NCH-1:0] b, e, t;
        for (int i = 0; i < NCH; i++) begin
            b[i] = (m_ph[v][i] == P_RUN);
            e[i] = (m_ph[v][i] == P_FAULT);
            t[i] = e[i] && m_tmo[v][i];
        end
        return {b, e, t, |b, |e};
    endfunction

    always @(negedge clk) begin
        check("state_latch", bus_l.state_q, exp_state(0));
        check("flags_latch", {bus_l.out_busy, bus_l.out_error, bus_l.out_tmo,
                              bus_l.any_busy, bus_l.any_error}, exp_flags(0));
        check("state_auto", bus_a.state_q, exp_state(1));
        check("flags_auto", {bus_a.out_busy, bus_a.out_error, bus_a.out_tmo,
                             bus_a.any_busy, bus_a.any_error}, exp_flags(1));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int n;

    initial begin
        model_reset();
        // Reset held three cycles
        step(3);
        check("rst_state", bus_l.state_q, 0);
        check("rst_flags", {bus_l.out_busy, bus_l.out_error, bus_l.out_tmo}, 0);
        check("rst_any", {bus_l.any_busy, bus_l.any_error, bus_a.any_busy, bus_a.any_error}, 0);
        rst_n = 1'b1;
        step(1);

        // Nominal ch0 with watchdog disabled
        s_start[0] = 1'b1;
        step(1);
        check("ch0_run", bus_l.state_q[0 +: SW], 1);
        check("ch0_busy", {bus_l.out_busy[0], bus_l.any_busy}, 2'b11);
        step(4);
        check("ch0_still_run_t0", bus_l.state_q[0 +: SW], 1);
        s_done[0] = 1'b1;
        step(1);
        check("ch0_done", {bus_l.state_q[0 +: SW], bus_l.out_busy[0]}, {3'd2, 1'b0});
        s_done[0] = 1'b0;
        step(2);
        check("ch0_hold_done", bus_l.state_q[0 +: SW], 2);
        s_start[0] = 1'b0;
        step(1);
        check("ch0_idle", bus_l.state_q, 0);

        // Watchdog ch1, T=5
        s_tmo = 16'd5;
        s_start[1] = 1'b1;
        step(1);
        n = 0;
        while (bus_l.out_busy[1] && n < 20) begin n++; step(1); end
        check("wd_run_len", n, 5);
        check("wd_fault", {bus_l.out_error[1], bus_l.out_tmo[1], bus_a.out_tmo[1]}, 3'b111);
        s_start[1] = 1'b0;
        s_clr[1] = 1'b1;
        step(1);
        s_clr[1] = 1'b0;
        check("wd_clear", {bus_l.state_q[SW +: SW], bus_l.out_tmo[1], bus_a.state_q[SW +: SW]}, 0);
        s_start[1] = 1'b1;
        step(5);
        s_done[1] = 1'b1;
        step(1);
        check("wd_done_wins", {bus_l.state_q[SW +: SW], bus_l.out_tmo[1]}, {3'd2, 1'b0});
        s_done[1] = 1'b0;
        s_start[1] = 1'b0;
        step(1);

        // Priority ch2: fault beats done, clr ignored while fault high
        s_tmo = '0;
        s_start[2] = 1'b1;
        step(1);
        s_fault[2] = 1'b1;
        s_done[2]  = 1'b1;
        step(1);
        check("pri_fault", {bus_l.state_q[2*SW +: SW], bus_l.out_tmo[2]}, {3'd3, 1'b0});
        s_done[2]  = 1'b0;
        s_start[2] = 1'b0;
        s_clr[2]   = 1'b1;
        step(1);
        check("pri_clr_ignored", bus_l.state_q[2*SW +: SW], 3);
        s_fault[2] = 1'b0;
        s_clr[2]   = 1'b0;
        step(1);
        check("latch_hold", bus_l.state_q[2*SW +: SW], 3);
        check("auto_exit", bus_a.state_q[2*SW +: SW], 0);
        step(2);
        check("latch_hold2", bus_l.out_error[2], 1);
        s_clr[2] = 1'b1;
        step(1);
        s_clr[2] = 1'b0;
        check("latch_clr", bus_l.state_q[2*SW +: SW], 0);

        // Async reset mid-RUN on every channel, then watchdog restarts from 0
        s_tmo = 16'd200;
        s_start = '1;
        step(10);
        check("all_busy", {bus_l.out_busy, bus_a.any_busy}, 5'b11111);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst", {bus_l.state_q, bus_l.any_busy, bus_a.state_q, bus_a.any_busy}, 0);
        s_tmo = 16'd5;
        step(1);
        rst_n = 1'b1;
        step(1);
        n = 0;
        while (bus_l.out_busy[3] && n < 20) begin n++; step(1); end
        check("rst_cnt_restart", n, 5);
        s_start = '0;
        s_clr = '1;
        step(1);
        s_clr = '0;
        step(1);

        // Randomized traffic, live timeout changes, occasional resets
        for (int c = 0; c < 3000; c++) begin
            step(1);
            rst_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 4))
                    0: s_tmo = '0;
                    1: s_tmo = 16'd1;
                    2: s_tmo = 16'd2;
                    default: s_tmo = TMO_W'($urandom_range(3, 30));
                endcase
            end
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 3) == 0) s_start[i] = ~s_start[i];
                s_done[i]  = ($urandom_range(0, 5) == 0);
                s_fault[i] = ($urandom_range(0, 29) == 0);
                s_clr[i]   = ($urandom_range(0, 3) == 0);
            end
        end
        rst_n = 1'b1;
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_ctrl_nch.md
# fsm_ctrl_nch

Parametrised, multi-channel successor to the single-channel start/done/fault controller: NCH independent IDLE/RUN/DONE/FAULT sequencers sharing one clock and reset. It adds a programmable RUN-phase watchdog timeout, a selectable sticky fault mode with explicit clear, and aggregated any-busy/any-error status. It sits between the per-channel request logic and the system status/interrupt block.

## Interface
- NCH, 4: number of channels (1..32)
- TMO_W, 16: width of watchdog counter and cfg_timeout
- FAULT_LATCH, 1: 1 = FAULT exits only on in_clr; 0 = FAULT auto-exits when fault and start are both low

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_start  in  NCH  per-channel start level
- in_done  in  NCH  per-channel done level
- in_fault  in  NCH  per-channel external fault level
- in_clr  in  NCH  per-channel fault-clear pulse (FAULT_LATCH=1 only; ignored when 0)
- cfg_timeout  in  TMO_W  RUN watchdog limit in cycles, shared by all channels; 0 disables
- out_busy  out  NCH  1 while channel in RUN
- out_error  out  NCH  1 while channel in FAULT
- out_tmo  out  NCH  1 while channel in FAULT entered via watchdog
- state_q  out  NCH*STATE_W  packed channel states, channel i at [i*STATE_W +: STATE_W]
- any_busy  out  1  OR of out_busy
- any_error  out  1  OR of out_error

## Operation
- Encoding: S_IDLE=0, S_RUN=1, S_DONE=2, S_FAULT=3, STATE_W=3; codes 4..7 illegal, next state S_FAULT.
- Per channel, evaluated each rising edge, priority top-down:
  - in_fault=1 in any state -> FAULT (out_tmo unchanged if already FAULT, else 0).
  - IDLE: in_start=1 -> RUN, cnt<=0.
  - RUN: in_done=1 -> DONE; else cfg_timeout!=0 and cnt>=cfg_timeout-1 -> FAULT, tmo<=1; else cnt<=cnt+1.
  - DONE: in_start=0 -> IDLE; otherwise hold.
  - FAULT, FAULT_LATCH=1: in_clr=1 and in_start=0 -> IDLE, tmo<=0; otherwise hold.
  - FAULT, FAULT_LATCH=0: in_start=0 -> IDLE, tmo<=0.
- cnt saturates at all-ones; never wraps.
- cfg_timeout is compared live; lowering it below the current cnt faults on the next edge.
- Channels fully independent; no arbitration or cross-channel effect.

## Timing
- Reset (async assert, sync release by top-level): all state_q=S_IDLE, cnt=0, every output 0.
- Outputs are Moore decodes of registered state: transition visible one cycle after the input is sampled, no combinational path from inputs to outputs.
- Watchdog: with cfg_timeout=T>0 and in_done low, channel shows RUN for exactly T cycles, then FAULT with out_tmo=1.
- Simultaneous events: fault beats done; done beats timeout on the same edge; in_clr with in_fault=1 ignored.
- in_start held high through DONE does not re-enter RUN; a falling edge to IDLE is required first.
- Reset asserted mid-RUN or mid-FAULT: immediate return to reset values, sticky tmo cleared.

## Structure
- Package fsm_ctrl_pkg: STATE_W, state localparams/enum, state_t typedef.
- Sub-module fsm_ch_core: one channel (state reg, cnt, tmo flag, output decode), parameters TMO_W and FAULT_LATCH.
- Top fsm_ctrl_nch: generate loop of NCH fsm_ch_core instances, state_q packing, any_busy/any_error reduction.

## Test plan
- Reset: hold rst_n=0 3 cycles -> all state_q=0, all outputs 0, any_busy=any_error=0.
- Nominal ch0, T=0: start -> RUN (busy=1, any_busy=1); done -> DONE (busy=0); start=0 -> IDLE; other channels stay IDLE.
- Watchdog ch1, T=5: start, done never -> exactly 5 cycles RUN then FAULT, out_error[1]=out_tmo[1]=1; done at cycle 5 instead -> DONE, tmo=0.
- Priority ch2: fault and done asserted same cycle in RUN -> FAULT, out_tmo=0; in_clr with fault still high -> stays FAULT.
- Latch mode: FAULT_LATCH=1, fault pulse then fault=start=0 -> stays FAULT until in_clr=1 -> IDLE; rebuild with FAULT_LATCH=0 -> IDLE one cycle after fault drops.
- Async reset mid-RUN on all 4 channels with T=200 -> all IDLE immediately, cnt restarts from 0 on next start.
